// File: rtl/seq_monitor.sv
// Lock/lap/error monitor for the 3-bit JK sequence counter's state vector.
// Tracks the fixed 8-state cycle and flags mismatches, laps and a stuck counter.
module seq_monitor #(
  parameter int unsigned LOCK_COUNT  = 4,
  parameter int unsigned STALL_LIMIT = 3,
  parameter int unsigned ERR_WIDTH   = 8,
  parameter int unsigned LAP_WIDTH   = 8
) (
  input  logic                 clk,
  input  logic                 clear,
  input  logic [2:0]           q_in,
  input  logic                 en,
  output logic [2:0]           step,
  output logic                 locked,
  output logic                 mismatch,
  output logic [ERR_WIDTH-1:0] err_count,
  output logic                 lap_pulse,
  output logic [LAP_WIDTH-1:0] lap_count,
  output logic                 fault
);

  typedef enum logic [1:0] {StIdle, StSync, StLocked, StFault} state_e;

  localparam logic [3:0]           LockCnt  = 4'(LOCK_COUNT);
  localparam logic [3:0]           StallLim = 4'(STALL_LIMIT);
  localparam logic [ERR_WIDTH-1:0] ErrMax   = '1;

  state_e               state_q, state_d;
  logic [2:0]           prev_q, prev_d;
  logic [2:0]           step_q, step_d;
  logic [3:0]           run_q, run_d;
  logic [3:0]           stall_q, stall_d;
  logic                 mismatch_q, mismatch_d;
  logic                 lap_pulse_q, lap_pulse_d;
  logic [ERR_WIDTH-1:0] err_q, err_d;
  logic [LAP_WIDTH-1:0] lap_q, lap_d;

  logic [2:0] exp_code;
  logic       pass;
  logic [3:0] stall_nxt;

  function automatic logic [2:0] succ_code(input logic [2:0] c);
    logic [2:0] n;
    unique case (c)
      3'b000:  n = 3'b100;
      3'b100:  n = 3'b101;
      3'b101:  n = 3'b001;
      3'b001:  n = 3'b111;
      3'b111:  n = 3'b110;
      3'b110:  n = 3'b011;
      3'b011:  n = 3'b010;
      default: n = 3'b000;
    endcase
    return n;
  endfunction

  function automatic logic [2:0] step_of(input logic [2:0] c);
    logic [2:0] s;
    unique case (c)
      3'b000:  s = 3'd0;
      3'b100:  s = 3'd1;
      3'b101:  s = 3'd2;
      3'b001:  s = 3'd3;
      3'b111:  s = 3'd4;
      3'b110:  s = 3'd5;
      3'b011:  s = 3'd6;
      default: s = 3'd7;
    endcase
    return s;
  endfunction

  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    step_d      = step_q;
    run_d       = run_q;
    stall_d     = stall_q;
    mismatch_d  = 1'b0;
    lap_pulse_d = 1'b0;
    err_d       = err_q;
    lap_d       = lap_q;

    exp_code  = en ? succ_code(prev_q) : prev_q;
    pass      = (q_in == exp_code);
    stall_nxt = (en && (q_in == prev_q)) ? stall_q + 4'd1 : 4'd0;

    unique case (state_q)
      StIdle: begin
        prev_d  = q_in;
        step_d  = step_of(q_in);
        run_d   = 4'd0;
        stall_d = 4'd0;
        state_d = StSync;
      end
      StSync, StLocked: begin
        prev_d  = q_in;
        step_d  = step_of(q_in);
        stall_d = stall_nxt;
        // A stall that reaches the limit wins over any check outcome this edge.
        if (stall_nxt == StallLim) begin
          state_d = StFault;
        end else if (state_q == StSync) begin
          if (pass) begin
            run_d = run_q + 4'd1;
            if ((run_q + 4'd1) == LockCnt) state_d = StLocked;
          end else begin
            run_d = 4'd0;
          end
        end else if (!pass) begin
          mismatch_d = 1'b1;
          if (err_q != ErrMax) err_d = err_q + ERR_WIDTH'(1);
          run_d   = 4'd0;
          state_d = StSync;
        end else if (en && (q_in == 3'b000)) begin
          lap_pulse_d = 1'b1;
          lap_d       = lap_q + LAP_WIDTH'(1);
        end
      end
      StFault: begin
        prev_d = q_in;
        step_d = step_of(q_in);
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clear) begin
      state_q     <= StIdle;
      prev_q      <= 3'b000;
      step_q      <= 3'd0;
      run_q       <= 4'd0;
      stall_q     <= 4'd0;
      mismatch_q  <= 1'b0;
      lap_pulse_q <= 1'b0;
      err_q       <= '0;
      lap_q       <= '0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      step_q      <= step_d;
      run_q       <= run_d;
      stall_q     <= stall_d;
      mismatch_q  <= mismatch_d;
      lap_pulse_q <= lap_pulse_d;
      err_q       <= err_d;
      lap_q       <= lap_d;
    end
  end

  assign step      = step_q;
  assign locked    = (state_q == StLocked);
  assign fault     = (state_q == StFault);
  assign mismatch  = mismatch_q;
  assign lap_pulse = lap_pulse_q;
  assign err_count = err_q;
  assign lap_count = lap_q;

endmodule

// File: tb/tb_seq_monitor.sv
// Directed and randomized bench for seq_monitor, checked against a cycle-position
// reference model of the monitor's rules.
module tb_seq_monitor;

  localparam int LOCK  = 4;
  localparam int STALL = 3;
  localparam int MIdle = 0, MSync = 1, MLocked = 2, MFault = 3;

  logic       clk;
  logic       clear;
  logic [2:0] q_in;
  logic       en;
  logic [2:0] step;
  logic       locked;
  logic       mismatch;
  logic [7:0] err_count;
  logic       lap_pulse;
  logic [7:0] lap_count;
  logic       fault;

  int checks;
  int errors;

  logic [2:0] codes [8] = '{3'b000, 3'b100, 3'b101, 3'b001, 3'b111, 3'b110, 3'b011, 3'b010};

  // Reference model state
  int         m_mode;
  logic [2:0] m_prev;
  int         m_run, m_stall, m_err, m_lap;
  logic       m_mis, m_lapp;

  seq_monitor #(
    .LOCK_COUNT (LOCK),
    .STALL_LIMIT(STALL),
    .ERR_WIDTH  (8),
    .LAP_WIDTH  (8)
  ) dut (
    .clk      (clk),
    .clear    (clear),
    .q_in     (q_in),
    .en       (en),
    .step     (step),
    .locked   (locked),
    .mismatch (mismatch),
    .err_count(err_count),
    .lap_pulse(lap_pulse),
    .lap_count(lap_count),
    .fault    (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int pos_of(input logic [2:0] c);
    for (int i = 0; i < 8; i++) if (codes[i] == c) return i;
    return 0;
  endfunction

  task automatic model_step(input logic c, input logic [2:0] q, input logic e);
    bit pass;
    if (!c) begin
      m_mode = MIdle; m_prev = 3'b000; m_run = 0; m_stall = 0;
      m_mis = 1'b0; m_lapp = 1'b0; m_err = 0; m_lap = 0;
      return;
    end
    m_mis  = 1'b0;
    m_lapp = 1'b0;
    if (m_mode == MSync || m_mode == MLocked) begin
      pass    = e ? (pos_of(q) == (pos_of(m_prev) + 1) % 8) : (q == m_prev);
      m_stall = (e && q == m_prev) ? m_stall + 1 : 0;
      if (m_stall == STALL) m_mode = MFault;
      else if (m_mode == MSync) begin
        if (pass) begin
          m_run++;
          if (m_run == LOCK) m_mode = MLocked;
        end else m_run = 0;
      end else if (!pass) begin
        m_mis = 1'b1;
        if (m_err < 255) m_err++;
        m_mode = MSync;
        m_run  = 0;
      end else if (e && pos_of(q) == 0) begin
        m_lapp = 1'b1;
        m_lap  = (m_lap + 1) % 256;
      end
    end else if (m_mode == MIdle) begin
      m_mode = MSync; m_run = 0; m_stall = 0;
    end
    m_prev = q;
  endtask

  // Drive one cycle of inputs, let the edge happen, sample 1 time unit later.
  task automatic tick(input logic c, input logic [2:0] q, input logic e);
    clear = c; q_in = q; en = e;
    @(posedge clk);
    model_step(c, q, e);
    #1;
  endtask

  task automatic test_reset();
    tick(1'b0, 3'b101, 1'b1);
    tick(1'b0, 3'b011, 1'b0);
    checks++; if (step !== 3'd0) begin errors++; $display("FAIL reset_step got %0d want 0", step); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %0b want 0", locked); end
    checks++; if (mismatch !== 1'b0) begin errors++; $display("FAIL reset_mismatch got %0b want 0", mismatch); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL reset_err got %0d want 0", err_count); end
    checks++; if (lap_pulse !== 1'b0) begin errors++; $display("FAIL reset_lap_pulse got %0b want 0", lap_pulse); end
    checks++; if (lap_count !== 8'd0) begin errors++; $display("FAIL reset_lap_count got %0d want 0", lap_count); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault got %0b want 0", fault); end
  endtask

  task automatic test_free_run();
    tick(1'b0, 3'b000, 1'b1);
    for (int i = 0; i <= 16; i++) begin
      tick(1'b1, codes[3'(i)], 1'b1);
      checks++; if (step !== 3'(i)) begin errors++; $display("FAIL free_step i=%0d got %0d want %0d", i, step, i % 8); end
      checks++; if (locked !== (i >= 4)) begin errors++; $display("FAIL free_locked i=%0d got %0b want %0b", i, locked, i >= 4); end
      checks++; if (lap_pulse !== (i == 8 || i == 16)) begin errors++; $display("FAIL free_lap_pulse i=%0d got %0b want %0b", i, lap_pulse, i == 8 || i == 16); end
      checks++; if (mismatch !== 1'b0) begin errors++; $display("FAIL free_mismatch i=%0d got %0b want 0", i, mismatch); end
      if (i == 8) begin
        checks++; if (lap_count !== 8'd1) begin errors++; $display("FAIL free_first_lap got %0d want 1", lap_count); end
      end
    end
    checks++; if (lap_count !== 8'd2) begin errors++; $display("FAIL free_lap_count got %0d want 2", lap_count); end
  endtask

  // Continues from LOCKED with the last sample at 000.
  task automatic test_mismatch();
    tick(1'b1, 3'b100, 1'b1);
    tick(1'b1, 3'b111, 1'b1);
    checks++; if (mismatch !== 1'b1) begin errors++; $display("FAIL mm_pulse got %0b want 1", mismatch); end
    checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL mm_err got %0d want 1", err_count); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL mm_unlock got %0b want 0", locked); end
    for (int k = 1; k <= 4; k++) begin
      tick(1'b1, codes[3'(4 + k)], 1'b1);
      checks++; if (mismatch !== 1'b0) begin errors++; $display("FAIL mm_pulse_end k=%0d got %0b want 0", k, mismatch); end
      checks++; if (locked !== (k == 4)) begin errors++; $display("FAIL mm_relock k=%0d got %0b want %0b", k, locked, k == 4); end
    end
    checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL mm_err_hold got %0d want 1", err_count); end
    checks++; if (lap_count !== 8'd2) begin errors++; $display("FAIL mm_no_sync_lap got %0d want 2", lap_count); end
  endtask

  // Continues from LOCKED with the last sample at 000.
  task automatic test_en_hold();
    int   p;
    logic ens [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    p = 0;
    for (int k = 0; k < 4; k++) begin
      if (ens[k]) p++;
      tick(1'b1, codes[3'(p)], ens[k]);
      checks++; if (mismatch !== 1'b0) begin errors++; $display("FAIL hold_mismatch k=%0d got %0b want 0", k, mismatch); end
      checks++; if (locked !== 1'b1) begin errors++; $display("FAIL hold_locked k=%0d got %0b want 1", k, locked); end
    end
    tick(1'b1, codes[3'(p + 1)], 1'b0);
    checks++; if (mismatch !== 1'b1) begin errors++; $display("FAIL hold_move got %0b want 1", mismatch); end
    checks++; if (err_count !== 8'd2) begin errors++; $display("FAIL hold_err got %0d want 2", err_count); end
  endtask

  task automatic test_stall();
    logic [2:0] q;
    tick(1'b0, 3'b000, 1'b1);
    for (int i = 0; i <= 5; i++) tick(1'b1, codes[3'(i)], 1'b1);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL stall_pre_lock got %0b want 1", locked); end
    tick(1'b1, 3'b110, 1'b1);
    checks++; if (mismatch !== 1'b1) begin errors++; $display("FAIL stall_rep1_mm got %0b want 1", mismatch); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL stall_rep1_fault got %0b want 0", fault); end
    tick(1'b1, 3'b110, 1'b1);
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL stall_rep2_fault got %0b want 0", fault); end
    tick(1'b1, 3'b110, 1'b1);
    checks++; if (fault !== 1'b1) begin errors++; $display("FAIL stall_rep3_fault got %0b want 1", fault); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL stall_rep3_locked got %0b want 0", locked); end
    checks++; if (mismatch !== 1'b0) begin errors++; $display("FAIL stall_rep3_mm got %0b want 0", mismatch); end
    checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL stall_err got %0d want 1", err_count); end
    for (int k = 0; k < 6; k++) begin
      q = 3'($urandom_range(0, 7));
      tick(1'b1, q, 1'($urandom_range(0, 1)));
      checks++; if (fault !== 1'b1) begin errors++; $display("FAIL fault_sticky k=%0d got %0b want 1", k, fault); end
      checks++; if (step !== 3'(pos_of(q))) begin errors++; $display("FAIL fault_step k=%0d got %0d want %0d", k, step, pos_of(q)); end
      checks++; if (mismatch !== 1'b0 || lap_pulse !== 1'b0) begin errors++; $display("FAIL fault_pulses k=%0d got %0b%0b want 00", k, mismatch, lap_pulse); end
      checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL fault_err k=%0d got %0d want 1", k, err_count); end
    end
    tick(1'b0, 3'b000, 1'b1);
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL fault_clear got %0b want 0", fault); end
  endtask

  task automatic test_saturate_wrap();
    int p;
    tick(1'b0, 3'b000, 1'b1);
    for (p = 0; p <= 4; p++) tick(1'b1, codes[3'(p)], 1'b1);
    p = 4;
    for (int n = 1; n <= 300; n++) begin
      p = p + 2;
      tick(1'b1, codes[3'(p)], 1'b1);
      checks++; if (mismatch !== 1'b1) begin errors++; $display("FAIL sat_mm n=%0d got %0b want 1", n, mismatch); end
      checks++; if (err_count !== 8'((n > 255) ? 255 : n)) begin errors++; $display("FAIL sat_err n=%0d got %0d want %0d", n, err_count, (n > 255) ? 255 : n); end
      for (int k = 0; k < 4; k++) begin
        p++;
        tick(1'b1, codes[3'(p)], 1'b1);
      end
    end
    tick(1'b0, 3'b000, 1'b1);
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL wrap_err_clr got %0d want 0", err_count); end
    for (int i = 0; i <= 2048; i++) begin
      tick(1'b1, codes[3'(i)], 1'b1);
      if (i == 2040) begin
        checks++; if (lap_count !== 8'd255) begin errors++; $display("FAIL wrap_pre got %0d want 255", lap_count); end
      end
    end
    checks++; if (lap_count !== 8'd0) begin errors++; $display("FAIL wrap_lap got %0d want 0", lap_count); end
    checks++; if (lap_pulse !== 1'b1) begin errors++; $display("FAIL wrap_pulse got %0b want 1", lap_pulse); end
  endtask

  task automatic test_mid_reset();
    int p;
    tick(1'b0, 3'b000, 1'b1);
    for (p = 0; p <= 4; p++) tick(1'b1, codes[3'(p)], 1'b1);
    p = 4;
    for (int n = 0; n < 3; n++) begin
      p = p + 2;
      tick(1'b1, codes[3'(p)], 1'b1);
      for (int k = 0; k < 6; k++) begin
        p++;
        tick(1'b1, codes[3'(p)], 1'b1);
      end
    end
    checks++; if (err_count !== 8'd3) begin errors++; $display("FAIL mid_err got %0d want 3", err_count); end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL mid_locked got %0b want 1", locked); end
    tick(1'b0, codes[3'(p + 1)], 1'b1);
    checks++; if ({step, locked, mismatch, err_count, lap_pulse, lap_count, fault} !== 22'd0) begin
      errors++;
      $display("FAIL mid_all_zero got step=%0d lk=%0b mm=%0b err=%0d lp=%0b lc=%0d f=%0b want all 0",
               step, locked, mismatch, err_count, lap_pulse, lap_count, fault);
    end
    p = 3;
    tick(1'b1, codes[3'(p)], 1'b1);
    checks++; if (step !== 3'd3 || locked !== 1'b0) begin errors++; $display("FAIL mid_capture got step=%0d lk=%0b want step=3 lk=0", step, locked); end
    for (int k = 1; k <= 4; k++) begin
      p++;
      tick(1'b1, codes[3'(p)], 1'b1);
      checks++; if (locked !== (k == 4)) begin errors++; $display("FAIL mid_relock k=%0d got %0b want %0b", k, locked, k == 4); end
    end
  endtask

  task automatic test_random();
    logic [2:0] q, last;
    logic       e, c;
    int         r, stuck;
    stuck = 0;
    tick(1'b0, 3'b000, 1'b1);
    last = 3'b000;
    for (int n = 0; n < 4000; n++) begin
      r = int'($urandom_range(0, 999));
      c = (r >= 4);
      if (stuck > 0) begin
        e = 1'b1; q = last; stuck--;
      end else if (r < 14) begin
        e = 1'b1; q = last; stuck = 3;
      end else begin
        e = ($urandom_range(0, 99) < 75);
        r = int'($urandom_range(0, 99));
        if (r < 8) q = 3'($urandom_range(0, 7));
        else q = e ? codes[3'(pos_of(last) + 1)] : last;
      end
      tick(c, q, e);
      last = q;
      checks++; if (step !== 3'(pos_of(m_prev))) begin errors++; $display("FAIL rnd_step n=%0d got %0d want %0d", n, step, pos_of(m_prev)); end
      checks++; if (locked !== (m_mode == MLocked)) begin errors++; $display("FAIL rnd_locked n=%0d got %0b want %0b", n, locked, m_mode == MLocked); end
      checks++; if (fault !== (m_mode == MFault)) begin errors++; $display("FAIL rnd_fault n=%0d got %0b want %0b", n, fault, m_mode == MFault); end
      checks++; if (mismatch !== m_mis) begin errors++; $display("FAIL rnd_mismatch n=%0d got %0b want %0b", n, mismatch, m_mis); end
      checks++; if (lap_pulse !== m_lapp) begin errors++; $display("FAIL rnd_lap_pulse n=%0d got %0b want %0b", n, lap_pulse, m_lapp); end
      checks++; if (err_count !== 8'(m_err)) begin errors++; $display("FAIL rnd_err n=%0d got %0d want %0d", n, err_count, m_err); end
      checks++; if (lap_count !== 8'(m_lap)) begin errors++; $display("FAIL rnd_lap_count n=%0d got %0d want %0d", n, lap_count, m_lap); end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clear  = 1'b0;
    q_in   = 3'b000;
    en     = 1'b0;
    model_step(1'b0, 3'b000, 1'b0);
    test_reset();
    test_free_run();
    test_mismatch();
    test_en_hold();
    test_stall();
    test_saturate_wrap();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
